// File: rtl/xidoo_pkg.sv
// Shared constants and enums for the memory arbiter slice.
// Imported by the arbiter top.
package xidoo_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    LOCK_PEND = 2'd1,
    LOCKED    = 2'd2
  } lock_state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU core and the host port,
// with starvation guard, read-data steering and a host lock handshake.
module mem_arbiter
  import xidoo_pkg::*;
#(
  parameter int ADDR_W        = xidoo_pkg::ADDR_W,
  parameter int DATA_W        = xidoo_pkg::DATA_W,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock_req,
  output logic              host_lock_ack,
  output logic              cpu_hold,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MAXW = 4'(HOST_MAX_WAIT);

  lock_state_t       state_q, state_d;
  logic              hold_q, ack_q;
  logic [3:0]        wait_q, wait_d;
  logic              rd_valid_q;
  owner_t            rd_owner_q;
  logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;
  logic              cpu_win, host_win;
  logic              wait_hit;

  assign wait_hit = (wait_q >= MAXW);

  // Pick at most one winner this cycle; nothing is granted in reset.
  always_comb begin
    cpu_win  = 1'b0;
    host_win = 1'b0;
    if (!reset) begin
      unique case (state_q)
        NORMAL: begin
          if (host_req && (!cpu_req || wait_hit))
            host_win = 1'b1;
          else if (cpu_req)
            cpu_win = 1'b1;
        end
        LOCKED:  host_win = host_req;
        default: ;
      endcase
    end
  end

  assign cpu_gnt  = cpu_win;
  assign host_gnt = host_win;
  assign mem_en   = cpu_win | host_win;

  // Steer the winner's command onto the memory port, zero when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (host_win) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Lock FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL:    if (host_lock_req) state_d = LOCK_PEND;
      LOCK_PEND: state_d = host_lock_req ? LOCKED : NORMAL;
      LOCKED:    if (!host_lock_req) state_d = NORMAL;
      default:   state_d = NORMAL;
    endcase
  end

  // Host starvation counter; frozen at zero while locked.
  always_comb begin
    wait_d = wait_q;
    if (state_q == LOCKED || !host_req || host_win)
      wait_d = '0;
    else if (!wait_hit)
      wait_d = wait_q + 4'd1;
  end

  // Lock state with its registered Moore outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= NORMAL;
      hold_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= (state_d != NORMAL);
      ack_q   <= (state_d == LOCKED);
    end
  end

  assign cpu_hold      = hold_q;
  assign host_lock_ack = ack_q;

  // Wait counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end

  // Track which side owns the read returning next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_CPU;
    end else begin
      rd_valid_q <= mem_en & ~mem_we;
      rd_owner_q <= host_win ? OWN_HOST : OWN_CPU;
    end
  end

  assign cpu_rvalid  = rd_valid_q && (rd_owner_q == OWN_CPU);
  assign host_rvalid = rd_valid_q && (rd_owner_q == OWN_HOST);

  // Hold each side's last returned word between its reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (cpu_rvalid)  cpu_rdata_q  <= mem_rdata;
      if (host_rvalid) host_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata  = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
  assign host_rdata = host_rvalid ? mem_rdata : host_rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port program/data memory between the accumulator CPU core and a host loader/debug port. It issues at most one memory access per cycle and steers the read data back to the requester that issued the read. It prevents host starvation with a bounded wait counter. It also provides a lock handshake that freezes the CPU controller while the host downloads a program.

Parameters:
ADDR_W, 5, memory address width (32 words)
DATA_W, 8, memory data width
HOST_MAX_WAIT, 4, cycles a pending host request may lose before it is forced to win (legal range 1..15)

Ports:
clock  in  1  master clock
reset  in  1  master reset
cpu_req  in  1  CPU access request, held until granted
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  access issued this cycle
cpu_rvalid  out  1  cpu_rdata valid
cpu_rdata  out  DATA_W  read data
host_req  in  1  host access request, held until granted
host_we  in  1  1 = write
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  access issued this cycle
host_rvalid  out  1  host_rdata valid
host_rdata  out  DATA_W  read data
host_lock_req  in  1  host requests exclusive ownership
host_lock_ack  out  1  exclusive ownership held
cpu_hold  out  1  freezes the CPU controller's state register
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  synchronous read data, valid 1 cycle after mem_en

Behaviour:
- Reset: clock is clock. reset is reset, asynchronous, active-high. While reset is high:
  - lock FSM = NORMAL, host wait counter = 0, read-owner pipeline cleared.
  - All outputs are 0: gnt, rvalid, cpu_hold, host_lock_ack, mem_en, mem_we. Data buses are also 0.
- Grant is combinational within the cycle: gnt = mem_en for the winner. mem_addr, mem_wdata and mem_we come from the winner's inputs.
- Zero-latency grant. A requester samples gnt at the clock edge and drops or changes its request after it.
- Arbitration in NORMAL:
  - Only one requester: that requester wins.
  - Both requesting: CPU wins, unless host_wait == HOST_MAX_WAIT, in which case the host wins.
- host_wait counter:
  - Increments each cycle host_req=1 and host_gnt=0.
  - Saturates at HOST_MAX_WAIT.
  - Clears on host_gnt or when host_req=0.
- Read return:
  - A registered owner bit plus a valid flag track each granted read.
  - Next cycle, the owner's rvalid is 1 for exactly one cycle and its rdata = mem_rdata.
  - The non-owner's rvalid is 0 and its rdata is held at the last value.
  - Writes produce no rvalid.
- Back-to-back reads by alternating owners each return correctly, with one read in flight per cycle.
- Lock FSM, states NORMAL, LOCK_PEND, LOCKED:
  - NORMAL → LOCK_PEND when host_lock_req=1. The grant in that same cycle follows normal arbitration.
  - LOCK_PEND: cpu_hold=1 and no grants to either side. This lets any in-flight read's rvalid drain. Always → LOCKED next cycle. If host_lock_req drops, → NORMAL instead.
  - LOCKED: cpu_hold=1 and host_lock_ack=1. Only host requests are granted; cpu_req is ignored and the wait counter is held at 0. → NORMAL when host_lock_req=0. cpu_hold and lock_ack drop in the NORMAL cycle.
- cpu_hold is a Moore output, decoded from the registered state only.
- Simultaneous events:
  - Lock request and starvation win in the same cycle: the host access is still granted in NORMAL.
  - Lock release with host_req high: in the NORMAL cycle the host competes normally.
- Reset mid-operation (for example in LOCKED, or with a read in flight): the lock drops and the pending rvalid is discarded.

Decomposition:
- Shared package xidoo_pkg holds:
  - ADDR_W and DATA_W constants.
  - The lock_state_t enum (NORMAL, LOCK_PEND, LOCKED).
  - The owner_t enum (OWN_CPU, OWN_HOST).
- One single module; no sub-module is warranted. The wait counter and read pipeline stay inline.

Test Plan:
- Reset: pulse reset during random traffic → all gnt, rvalid, cpu_hold, lock_ack and mem_en are 0 immediately. After release, the FSM is in NORMAL and the first cpu_req is granted the same cycle.
- CPU read alone: mem[5]=0x2A; cpu_req=1, we=0, addr=5 → cycle 0: cpu_gnt=1, mem_en=1, mem_addr=5. Cycle 1: cpu_rvalid=1, cpu_rdata=0x2A, host_rvalid=0.
- Contention with HOST_MAX_WAIT=4: both requesters held high → cpu_gnt in cycles 0–3, host_gnt in cycle 4, cpu_gnt in cycles 5–8, host_gnt in cycle 9.
- Alternating reads: CPU read of addr 1 (0x11) in cycle 0, forced host read of addr 2 (0x22) in cycle 1 → cpu_rvalid with 0x11 in cycle 1, host_rvalid with 0x22 in cycle 2, never crossed.
- Lock: host_lock_req rises at cycle t while the CPU is streaming reads →
  - t: normal grant.
  - t+1: LOCK_PEND, cpu_hold=1, no grants, the in-flight CPU rvalid appears.
  - t+2: lock_ack=1.
  - Host writes 0xE5 to addr 31 and cpu_req gets no grant. Host drops the lock, then a CPU read of 31 returns 0xE5.
- Reset in LOCKED with a host read in flight → cpu_hold, lock_ack and host_rvalid go to 0 asynchronously. No rvalid after release.
